// File: rtl/ledger_writer.sv
// rtl/ledger_writer.sv - framebuffer write side: raster stream packer and single-pixel read-modify-write plotter
// Eight 4-bit pixels per word with x%8==0 in bits 31:28; word address is 80*y + x[9:3].
module ledger_writer #(
  parameter int unsigned ROWS = 480,
  parameter int unsigned COLS = 80,
  parameter int unsigned AW   = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [3:0]    pix_gray,
  output logic          pix_ready,
  input  logic          plot_valid,
  input  logic [9:0]    plot_x,
  input  logic [9:0]    plot_y,
  input  logic [3:0]    plot_gray,
  output logic          plot_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [AW-1:0] LAST_WORD = AW'(ROWS * COLS - 1);

  typedef enum logic [2:0] {IDLE, STREAM, PLOT_RD, PLOT_MERGE, PLOT_WR} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] word_addr;
  logic [2:0]    nib_cnt;
  logic [27:0]   sr;
  logic [2:0]    plot_k;
  logic [3:0]    plot_val;

  logic          plot_take;
  logic          plot_in_range;
  logic          pix_take;
  logic          word_full;
  logic          last_word;
  logic [AW-1:0] plot_lin;
  logic [31:0]   merged;

  assign plot_ready    = (state == IDLE) && !start;
  assign pix_ready     = (state == STREAM);
  assign busy          = (state != IDLE);
  assign plot_take     = plot_valid && plot_ready;
  assign plot_in_range = (32'(plot_x) < COLS * 8) && (32'(plot_y) < ROWS);
  // 80-word row stride as y*64 + y*16
  assign plot_lin      = (AW'(plot_y) << 6) + (AW'(plot_y) << 4) + AW'(plot_x[9:3]);
  assign pix_take      = (state == STREAM) && !start && pix_valid;
  assign word_full     = pix_take && (nib_cnt == 3'd7);
  assign last_word     = (word_addr == LAST_WORD);

  always_comb begin
    merged = mem_rdata;
    merged[{~plot_k, 2'b00} +: 4] = plot_val;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
        end else if (plot_take && plot_in_range) begin
          state_nxt = PLOT_RD;
        end
      end
      STREAM: begin
        if (word_full && last_word) begin
          state_nxt = IDLE;
        end
      end
      PLOT_RD:    state_nxt = PLOT_MERGE;
      PLOT_MERGE: state_nxt = PLOT_WR;
      PLOT_WR:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      word_addr  <= '0;
      nib_cnt    <= '0;
      sr         <= '0;
      plot_k     <= '0;
      plot_val   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      // A restart leaves stale nibbles in sr; they are shifted out before the next full word
      if (start && (state == IDLE || state == STREAM)) begin
        word_addr <= '0;
        nib_cnt   <= '0;
      end else if (pix_take) begin
        sr      <= {sr[23:0], pix_gray};
        nib_cnt <= nib_cnt + 3'd1;
        if (word_full) begin
          mem_we     <= 1'b1;
          mem_addr   <= word_addr;
          mem_wdata  <= {sr, pix_gray};
          word_addr  <= last_word ? '0 : word_addr + AW'(1);
          frame_done <= last_word;
        end
      end
      if (plot_take && plot_in_range) begin
        mem_addr <= plot_lin;
        plot_k   <= plot_x[2:0];
        plot_val <= plot_gray;
      end
      if (state == PLOT_MERGE) begin
        mem_wdata <= merged;
        mem_we    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ledger_writer.sv
// tb/tb_ledger_writer.sv - self-checking bench for ledger_writer
// Frame height is reduced so a complete frame stream stays short; row stride stays 80 words.
module tb_ledger_writer;
  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 80;
  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = ROWS * COLS;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          pix_valid;
  logic [3:0]    pix_gray;
  logic          pix_ready;
  logic          plot_valid;
  logic [9:0]    plot_x;
  logic [9:0]    plot_y;
  logic [3:0]    plot_gray;
  logic          plot_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          frame_done;

  ledger_writer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .pix_valid(pix_valid), .pix_gray(pix_gray), .pix_ready(pix_ready),
    .plot_valid(plot_valid), .plot_x(plot_x), .plot_y(plot_y), .plot_gray(plot_gray),
    .plot_ready(plot_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          fd;
  } wr_t;

  typedef struct {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [3:0]    g;
    logic [31:0]   pre;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } pv_t;

  wr_t           wlog[$];
  logic [31:0]   ram [WORDS];
  int            fd_alone = 0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  // Synchronous-read RAM plus a log of every write the DUT issues
  always @(posedge Clk) begin
    if (mem_addr < WORDS) mem_rdata <= ram[mem_addr];
    else                  mem_rdata <= '0;
    if (pre_en) ram[pre_addr] <= pre_data;
    if (mem_we) begin
      if (mem_addr < WORDS) ram[mem_addr] <= mem_wdata;
      wlog.push_back('{mem_addr, mem_wdata, frame_done});
    end
    if (frame_done && !mem_we) fd_alone++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick(1);
    pre_en   = 1'b0;
  endtask

  function automatic logic [31:0] ramp_word(input int first);
    logic [31:0] d = '0;
    for (int j = 0; j < 8; j++) d = d | (32'((first + j) % 16) << (28 - 4 * j));
    return d;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  pv_t pv [8];
  wr_t exp_q[$];
  logic [3:0] pend[$];

  initial begin
    int base, nbad, fd0, m_word, rdy_bad;
    logic m_in;
    logic [31:0] d;
    logic [3:0] wep, bsy;

    pv[0] = '{10'd13,  10'd2,       4'hA, 32'h11111111, 1'b1, 16'd161,             32'h11111A11};
    pv[1] = '{10'd639, 10'(ROWS-1), 4'hF, 32'h00000000, 1'b1, 16'(WORDS - 1),      32'h0000000F};
    pv[2] = '{10'd0,   10'd0,       4'h5, 32'hFFFFFFFF, 1'b1, 16'd0,               32'h5FFFFFFF};
    pv[3] = '{10'd640, 10'd0,       4'h7, 32'h0,        1'b0, 16'd0,               32'h0};
    pv[4] = '{10'd5,   10'd479,     4'h7, 32'h0,        1'b0, 16'd0,               32'h0};
    pv[5] = '{10'd1023,10'd1023,    4'h7, 32'h0,        1'b0, 16'd0,               32'h0};
    pv[6] = '{10'd7,   10'd3,       4'h0, 32'hFFFFFFFF, 1'b1, 16'd240,             32'hFFFFFFF0};
    pv[7] = '{10'd322, 10'd9,       4'h6, 32'h12345678, 1'b1, 16'd760,             32'h12645678};

    Reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_gray = '0;
    plot_valid = 1'b0; plot_x = '0; plot_y = '0; plot_gray = '0;
    tick(2);
    check("rst_mem_we",     mem_we,     0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy",       busy,       0);
    check("rst_pix_ready",  pix_ready,  0);
    check("rst_plot_ready", plot_ready, 1);
    Reset = 1'b0;
    tick(1);

    // Plot vectors, including out-of-range drops
    for (int i = 0; i < 8; i++) begin
      if (pv[i].wr) preload(pv[i].addr, pv[i].pre);
      plot_x = pv[i].x; plot_y = pv[i].y; plot_gray = pv[i].g; plot_valid = 1'b1;
      #1;
      check($sformatf("plot%0d_ready", i), plot_ready, 1);
      base = wlog.size();
      tick(1);
      plot_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        wep[c] = mem_we;
        bsy[c] = busy;
        if (c < 3) tick(1);
      end
      check($sformatf("plot%0d_we_timing", i), wep, pv[i].wr ? 4'b0100 : 4'b0000);
      check($sformatf("plot%0d_busy", i),      bsy, pv[i].wr ? 4'b0111 : 4'b0000);
      check($sformatf("plot%0d_ready_back", i), plot_ready, 1);
      check($sformatf("plot%0d_nwrites", i), wlog.size() - base, pv[i].wr ? 1 : 0);
      if (pv[i].wr && wlog.size() > base) begin
        check($sformatf("plot%0d_addr", i), wlog[base].addr, pv[i].addr);
        check($sformatf("plot%0d_data", i), wlog[base].data, pv[i].data);
      end
    end

    // start wins over a simultaneous plot, then mid-stream restart
    base = wlog.size();
    plot_x = 10'd1; plot_y = 10'd1; plot_gray = 4'h9;
    start = 1'b1; plot_valid = 1'b1;
    #1;
    check("prio_plot_ready", plot_ready, 0);
    tick(1);
    start = 1'b0; plot_valid = 1'b0;
    check("prio_stream", {busy, pix_ready}, 2'b11);
    pix_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      pix_gray = 4'(i);
      tick(1);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pix_gray = 4'h3;
    tick(8);
    pix_valid = 1'b0;
    tick(1);
    check("restart_nwrites", wlog.size() - base, 2);
    if (wlog.size() - base == 2) begin
      check("restart_w0", {wlog[base].addr, wlog[base].data},         {16'd0, 32'h12345678});
      check("restart_w1", {wlog[base + 1].addr, wlog[base + 1].data}, {16'd0, 32'h33333333});
    end

    // Complete frame with gray = i%16, no gaps
    base = wlog.size();
    fd0  = fd_alone;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < int'(WORDS * 8); i++) begin
      pix_gray = 4'(i % 16);
      tick(1);
    end
    pix_valid = 1'b0;
    check("full_last_we_fd", {mem_we, frame_done}, 2'b11);
    check("full_last_addr", mem_addr, WORDS - 1);
    check("full_pix_ready_after", pix_ready, 0);
    check("full_busy_after", busy, 0);
    tick(2);
    check("full_nwrites", wlog.size() - base, WORDS);
    check("full_fd_alone", fd_alone - fd0, 0);
    if (wlog.size() - base == WORDS) begin
      check("full_addr0", wlog[base].data, 32'h01234567);
      check("full_addr1", wlog[base + 1].data, 32'h89ABCDEF);
      nbad = 0;
      for (int w = 0; w < int'(WORDS); w++) begin
        if (wlog[base + w].addr != 16'(w) || wlog[base + w].data != ramp_word(8 * w) ||
            wlog[base + w].fd != (w == int'(WORDS) - 1)) nbad++;
      end
      check("full_all_words", nbad, 0);
    end

    // Randomized stream with gaps and restarts against a pixel-queue model
    base = wlog.size();
    exp_q.delete(); pend.delete();
    m_in = 1'b0; m_word = 0; rdy_bad = 0;
    for (int c = 0; c < 3000; c++) begin
      logic st, v;
      logic [3:0] g;
      st = (c == 0) || ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      g  = 4'($urandom);
      start = st; pix_valid = v; pix_gray = g;
      if (st) begin
        m_in = 1'b1; m_word = 0; pend.delete();
      end else if (m_in && v) begin
        pend.push_back(g);
        if (pend.size() == 8) begin
          d = '0;
          foreach (pend[j]) d = d | (32'(pend[j]) << (28 - 4 * j));
          exp_q.push_back('{16'(m_word), d, m_word == int'(WORDS) - 1});
          pend.delete();
          m_word++;
          if (m_word == int'(WORDS)) begin
            m_in = 1'b0; m_word = 0;
          end
        end
      end
      tick(1);
      if (pix_ready !== m_in) rdy_bad++;
    end
    start = 1'b0; pix_valid = 1'b0;
    tick(1);
    check("rand_pix_ready", rdy_bad, 0);
    check("rand_nwrites", wlog.size() - base, exp_q.size());
    nbad = 0;
    for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++) begin
      if (wlog[base + i].addr != exp_q[i].addr || wlog[base + i].data != exp_q[i].data ||
          wlog[base + i].fd != exp_q[i].fd) nbad++;
    end
    check("rand_writes", nbad, 0);

    // Reset at pixel 5 of a stream
    base = wlog.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_gray = 4'(i + 1);
      tick(1);
    end
    Reset = 1'b1;
    tick(1);
    check("rst_stream_pix_ready", pix_ready, 0);
    check("rst_stream_busy", busy, 0);
    Reset = 1'b0;
    tick(8);
    pix_valid = 1'b0;
    tick(1);
    check("rst_stream_nwrites", wlog.size() - base, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 8; i < 16; i++) begin
      pix_gray = 4'(i);
      tick(1);
    end
    pix_valid = 1'b0;
    tick(1);
    check("rst_stream_fresh_n", wlog.size() - base, 1);
    if (wlog.size() - base == 1)
      check("rst_stream_fresh_w", {wlog[base].addr, wlog[base].data}, {16'd0, 32'h89ABCDEF});

    // Reset during PLOT_MERGE
    start = 1'b1;
    tick(1);
    start = 1'b0;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    preload(16'd83, 32'h0);
    base = wlog.size();
    plot_x = 10'd24; plot_y = 10'd1; plot_gray = 4'hC; plot_valid = 1'b1;
    tick(1);
    plot_valid = 1'b0;
    tick(1);
    check("rst_plot_busy_pre", busy, 1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    #1;
    check("rst_plot_we", mem_we, 0);
    check("rst_plot_busy", busy, 0);
    check("rst_plot_ready", plot_ready, 1);
    tick(4);
    check("rst_plot_nwrites", wlog.size() - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
